// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding,
// tx_status field positions and stop-bit encodings.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } uart_state_e;

  localparam int ST_STROBE    = 0;
  localparam int ST_DBITS_LSB = 1;
  localparam int ST_PARITY    = 5;
  localparam int ST_STOP_LSB  = 6;

  localparam logic [1:0] STOP_ONE = 2'd1;
  localparam logic [1:0] STOP_TWO = 2'd2;

  // 0 is promoted to one stop bit, anything above two is clamped to two.
  function automatic logic [1:0] stop_encode(input logic [1:0] cfg);
    return (cfg == 2'd2 || cfg == 2'd3) ? STOP_TWO : STOP_ONE;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after i_rr_ptr,
// wrapping from NUM_REQ-1 back to 0.
module uart_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_rr_ptr,
  output logic               o_any,
  output logic [PTR_W-1:0]   o_winner
);

  logic [PTR_W-1:0] w_idx;

  // Scan from the farthest offset down so the nearest set request wins.
  always_comb begin
    o_any    = 1'b0;
    o_winner = '0;
    w_idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = PTR_W'((int'(i_rr_ptr) + k) % NUM_REQ);
      if (i_req[w_idx]) begin
        o_any    = 1'b1;
        o_winner = w_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter. Optional WAIT timeout
// with sticky timeout_err is enabled by defining UART_TX_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no frame in flight; arbitrate pending requests
// GRANT | one-cycle gnt pulse to the latched winner
// START | one-cycle transmit strobe with latched config
// WAIT  | frame on the wire; leave on tx_done (or timeout)
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
`ifdef UART_TX_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 2_000_000
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  input  logic [3:0]                   cfg_data_bits,
  input  logic                         cfg_parity_en,
  input  logic [1:0]                   cfg_stop_bits,
  input  logic                         tx_done,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [31:0]                  tx_data,
  output logic [31:0]                  tx_status,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   owner
`ifdef UART_TX_ARB_TIMEOUT_EN
  ,
  output logic                         timeout_err
`endif
);

  localparam int PW = $clog2(NUM_REQ);

  uart_state_e       r_state;
  uart_state_e       w_next;
  logic [PW-1:0]     r_rr_ptr;
  logic [PW-1:0]     r_owner;
  logic [DATA_W-1:0] r_data;
  logic [3:0]        r_data_bits;
  logic              r_parity;
  logic [1:0]        r_stop;
  logic              w_any;
  logic [PW-1:0]     w_winner;
  logic              w_latch;
  logic              w_to_hit;

  uart_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PW)
  ) u_rr (
    .i_req    (req),
    .i_rr_ptr (r_rr_ptr),
    .o_any    (w_any),
    .o_winner (w_winner)
  );

  assign w_latch = (r_state == IDLE) && w_any;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_data      <= '0;
      r_data_bits <= '0;
      r_parity    <= 1'b0;
      r_stop      <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_owner     <= w_winner;
        r_rr_ptr    <= (w_winner == PW'(NUM_REQ - 1)) ? '0 : w_winner + PW'(1);
        r_data      <= req_data[int'(w_winner)*DATA_W +: DATA_W];
        r_data_bits <= cfg_data_bits;
        r_parity    <= cfg_parity_en;
        r_stop      <= stop_encode(cfg_stop_bits);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = GRANT;
      GRANT:   w_next = START;
      START:   w_next = WAIT;
      WAIT:    if (tx_done || w_to_hit) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] r_to_cnt;
  logic          r_timeout_err;

  // Loaded on the way into WAIT so that WAIT lasts exactly TIMEOUT_CYC cycles.
  assign w_to_hit = (r_state == WAIT) && !tx_done && (r_to_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == START)
        r_to_cnt <= TW'(TIMEOUT_CYC - 1);
      else if (r_state == WAIT && r_to_cnt != '0)
        r_to_cnt <= r_to_cnt - TW'(1);
      if (w_to_hit)
        r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_to_hit = 1'b0;
`endif

  always_comb begin
    gnt = '0;
    if (r_state == GRANT) gnt[r_owner] = 1'b1;
  end

  always_comb begin
    tx_status                       = '0;
    tx_status[ST_STOP_LSB +: 2]     = r_stop;
    tx_status[ST_PARITY]            = r_parity;
    tx_status[ST_DBITS_LSB +: 4]    = r_data_bits;
    tx_status[ST_STROBE]            = (r_state == START);
  end

  assign tx_data = 32'(r_data);
  assign busy    = (r_state != IDLE);
  assign owner   = r_owner;

endmodule
